xy_capture_fifo: RTL and testbench

- Downstream consumer of the dual-nibble block (D in; X, Y out).
- On each enabled clock it packs the two 4-bit outputs into one byte, {X,Y}.
- It can filter out unchanged samples and buffers the bytes in a small FIFO.
- The FIFO drains through a valid/ready interface to the next stage (display/log/UART).

---
 rtl/xy_pkg.sv | 12 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/xy_capture_fifo.sv | 78 +++++++
 tb/tb_xy_capture_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xy_pkg.sv
// Shared types and helpers for the X/Y nibble capture path.
package xy_pkg;

  localparam int XY_W = 4;

  typedef logic [2*XY_W-1:0] xy_byte_t;

  function automatic xy_byte_t pack_xy(input logic [XY_W-1:0] x, input logic [XY_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and an occupancy counter.
// The caller must only push when not full (or when popping) and only pop when not empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; stale entries are hidden by the empty check on rdata.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    full  = (level == FULL_LEVEL);
    empty = (level == '0);
    rdata = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/xy_capture_fifo.sv
// Packs X/Y nibbles into bytes, optionally drops repeats, and buffers them
// for a valid/ready consumer with a sticky overflow flag.
module xy_capture_fifo
  import xy_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter bit CHANGE_ONLY = 1'b1
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   In_Valid,
  input  logic [XY_W-1:0]        X,
  input  logic [XY_W-1:0]        Y,
  output xy_byte_t               Out_Data,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [$clog2(DEPTH):0] Level,
  output logic                   Overflow,
  input  logic                   Clr_Ovf
);

  xy_byte_t cand;
  xy_byte_t last_byte;
  logic     have_last;
  logic     want_push;
  logic     push;
  logic     pop;
  logic     drop;
  logic     full;
  logic     empty;

  // A full FIFO still takes a new byte when the head leaves in the same cycle.
  always_comb begin
    cand      = pack_xy(X, Y);
    want_push = In_Valid && (!CHANGE_ONLY || !have_last || (cand != last_byte));
    pop       = !empty && Out_Ready;
    push      = want_push && (!full || pop);
    drop      = want_push && full && !pop;
    Out_Valid = !empty;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_byte <= '0;
      have_last <= 1'b0;
    end else if (push) begin
      last_byte <= cand;
      have_last <= 1'b1;
    end
  end

  // A drop in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Overflow <= 1'b0;
    end else if (drop) begin
      Overflow <= 1'b1;
    end else if (Clr_Ovf) begin
      Overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(xy_byte_t))
  ) u_fifo (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (cand),
    .rdata (Out_Data),
    .level (Level),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_xy_capture_fifo.sv
// Self-checking bench for xy_capture_fifo: directed scenarios plus a randomized
// run compared against a queue-based reference model of the filtered FIFO.
module tb_xy_capture_fifo;

  localparam int DEPTH = 4;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       In_Valid = 1'b0;
  logic       Out_Ready = 1'b0;
  logic       Clr_Ovf = 1'b0;
  logic [3:0] X = 4'h0;
  logic [3:0] Y = 4'h0;

  logic [7:0] Out_Data;
  logic       Out_Valid;
  logic [2:0] Level;
  logic       Overflow;

  logic [7:0] all_data;
  logic       all_valid;
  logic [2:0] all_level;
  logic       all_ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: queue contents, last accepted byte, sticky overflow.
  logic [7:0] mq [$];
  logic [7:0] m_last = 8'h00;
  bit         m_have = 1'b0;
  bit         m_ovf  = 1'b0;

  always #5 Clk = ~Clk;

  xy_capture_fifo #(.DEPTH(DEPTH), .CHANGE_ONLY(1'b1)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .X         (X),
    .Y         (Y),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Level     (Level),
    .Overflow  (Overflow),
    .Clr_Ovf   (Clr_Ovf)
  );

  xy_capture_fifo #(.DEPTH(DEPTH), .CHANGE_ONLY(1'b0)) dut_all (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .X         (X),
    .Y         (Y),
    .Out_Data  (all_data),
    .Out_Valid (all_valid),
    .Out_Ready (Out_Ready),
    .Level     (all_level),
    .Overflow  (all_ovf),
    .Clr_Ovf   (Clr_Ovf)
  );

  function automatic logic [7:0] model_head();
    return (mq.size() != 0) ? mq[0] : 8'h00;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = 8'h00;
    m_have = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [7:0] b, input bit rdy, input bit clr);
    In_Valid  = v;
    X         = b[7:4];
    Y         = b[3:0];
    Out_Ready = rdy;
    Clr_Ovf   = clr;
  endtask

  // Advance one clock edge, updating the model from the inputs held across it;
  // returns at the following falling edge where outputs are sampled.
  task automatic cycle();
    logic [7:0] cand;
    bit pop_m, want, drop, accept;
    @(posedge Clk);
    cand   = {X, Y};
    pop_m  = (mq.size() != 0) && Out_Ready;
    want   = In_Valid && (!m_have || cand != m_last);
    drop   = want && (mq.size() == DEPTH) && !pop_m;
    accept = want && !drop;
    if (pop_m) void'(mq.pop_front());
    if (accept) begin
      mq.push_back(cand);
      m_last = cand;
      m_have = 1'b1;
    end
    m_ovf = drop ? 1'b1 : (Clr_Ovf ? 1'b0 : m_ovf);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    drive(0, 8'h00, 0, 0);
    repeat (2) @(negedge Clk);
    model_reset();
    checks++; if (Level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", Level); end
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", Out_Valid); end
    checks++; if (Out_Data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", Out_Data); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", Overflow); end
    checks++; if (all_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_all_level got %0d want 0", all_level); end
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_change_filter();
    drive(1, 8'h10, 0, 0);
    repeat (3) cycle();
    drive(1, 8'h31, 0, 0);
    cycle();
    checks++; if (Level !== 3'd2) begin errors++; $display("[TB] FAIL filter_level got %0d want 2", Level); end
    checks++; if (Out_Data !== 8'h10) begin errors++; $display("[TB] FAIL filter_head got %h want 10", Out_Data); end
    checks++; if (all_level !== 3'd4) begin errors++; $display("[TB] FAIL nofilter_level got %0d want 4", all_level); end
    checks++; if (all_data !== 8'h10) begin errors++; $display("[TB] FAIL nofilter_head got %h want 10", all_data); end
    drive(0, 8'h00, 1, 0);
    cycle();
    checks++; if (Out_Data !== 8'h31) begin errors++; $display("[TB] FAIL filter_after_pop got %h want 31", Out_Data); end
    checks++; if (Level !== 3'd1) begin errors++; $display("[TB] FAIL filter_level_pop got %0d want 1", Level); end
    cycle();
    checks++; if (Level !== 3'd0) begin errors++; $display("[TB] FAIL filter_drained got %0d want 0", Level); end
  endtask

  task automatic test_overflow();
    logic [7:0] fill [4];
    fill[0] = 8'hA1; fill[1] = 8'hA2; fill[2] = 8'hA3; fill[3] = 8'hA4;
    for (int i = 0; i < 4; i++) begin
      drive(1, fill[i], 0, 0);
      cycle();
    end
    checks++; if (Level !== 3'd4) begin errors++; $display("[TB] FAIL ovf_full_level got %0d want 4", Level); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_before got %b want 0", Overflow); end
    drive(1, 8'hA5, 0, 0);
    cycle();
    checks++; if (Level !== 3'd4) begin errors++; $display("[TB] FAIL ovf_drop_level got %0d want 4", Level); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b want 1", Overflow); end
    checks++; if (Out_Data !== 8'hA1) begin errors++; $display("[TB] FAIL ovf_head got %h want a1", Out_Data); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'hA2; exp_seq[1] = 8'hA3; exp_seq[2] = 8'hA4; exp_seq[3] = 8'hB0;
    drive(1, 8'hB0, 1, 0);
    cycle();
    checks++; if (Level !== 3'd4) begin errors++; $display("[TB] FAIL fullpop_level got %0d want 4", Level); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_ovf got %b want 1", Overflow); end
    drive(0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Out_Data !== exp_seq[i]) begin
        errors++; $display("[TB] FAIL drain_%0d got %h want %h", i, Out_Data, exp_seq[i]);
      end
      cycle();
    end
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty got %b want 0", Out_Valid); end
  endtask

  task automatic test_overflow_clear();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'hC0 + 8'(i), 0, 0);
      cycle();
    end
    drive(1, 8'hC5, 0, 1);
    cycle();
    checks++; if (Overflow !== 1'b1) begin errors++; $display("[TB] FAIL clr_vs_drop got %b want 1", Overflow); end
    checks++; if (Level !== 3'd4) begin errors++; $display("[TB] FAIL clr_level got %0d want 4", Level); end
    drive(0, 8'h00, 0, 1);
    cycle();
    checks++; if (Overflow !== 1'b0) begin errors++; $display("[TB] FAIL clr_only got %b want 0", Overflow); end
    drive(0, 8'h00, 1, 0);
    repeat (4) cycle();
    checks++; if (Level !== 3'd0) begin errors++; $display("[TB] FAIL clr_drain got %0d want 0", Level); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'hE0 + 8'(i), 1, 0);
      cycle();
      checks++;
      if (Level !== 3'd1 || Out_Data !== 8'hE0 + 8'(i)) begin
        errors++; $display("[TB] FAIL b2b_%0d got level %0d data %h want level 1 data %h", i, Level, Out_Data, 8'hE0 + 8'(i));
      end
    end
    drive(0, 8'h00, 1, 0);
    cycle();
    checks++; if (Level !== 3'd0) begin errors++; $display("[TB] FAIL b2b_end got %0d want 0", Level); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 8'hD0 + 8'(i), 0, 0);
      cycle();
    end
    checks++; if (Level !== 3'd3) begin errors++; $display("[TB] FAIL arst_pre got %0d want 3", Level); end
    drive(0, 8'h00, 0, 0);
    #2 Rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (Level !== 3'd0) begin errors++; $display("[TB] FAIL arst_level got %0d want 0", Level); end
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid got %b want 0", Out_Valid); end
    checks++; if (Out_Data !== 8'h00) begin errors++; $display("[TB] FAIL arst_data got %h want 00", Out_Data); end
    @(negedge Clk);
    Rst_n = 1'b1;
    drive(1, 8'h00, 0, 0);
    cycle();
    checks++;
    if (Level !== 3'd1 || Out_Valid !== 1'b1 || Out_Data !== 8'h00) begin
      errors++; $display("[TB] FAIL arst_first got level %0d valid %b data %h want 1 1 00", Level, Out_Valid, Out_Data);
    end
    drive(1, 8'h55, 0, 0);
    cycle();
    checks++; if (Level !== 3'd2) begin errors++; $display("[TB] FAIL arst_55 got %0d want 2", Level); end
    drive(0, 8'h00, 1, 0);
    repeat (2) cycle();
  endtask

  // Small value range forces frequent repeats so the change filter is exercised.
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 3) * 16 + $urandom_range(0, 2)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      cycle();
      checks++;
      if (Level !== 3'(mq.size())) begin errors++; $display("[TB] FAIL rnd_level_%0d got %0d want %0d", n, Level, mq.size()); end
      checks++;
      if (Out_Valid !== (mq.size() != 0)) begin errors++; $display("[TB] FAIL rnd_valid_%0d got %b want %b", n, Out_Valid, mq.size() != 0); end
      checks++;
      if (Out_Data !== model_head()) begin errors++; $display("[TB] FAIL rnd_data_%0d got %h want %h", n, Out_Data, model_head()); end
      checks++;
      if (Overflow !== m_ovf) begin errors++; $display("[TB] FAIL rnd_ovf_%0d got %b want %b", n, Overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_change_filter();
    test_overflow();
    test_full_pop();
    test_overflow_clear();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
